mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter AW, default 8, meaning main-memory word-address width.
REQ-002 The block SHALL have parameter DW, default 32, meaning data width.
REQ-003 The block SHALL have parameter LINE_WORDS, default 4, meaning words per cache-line refill (power of two, at least 2).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rd_req  in  1  cache-line refill request; held high by requester until rd_done.
REQ-007 rd_addr  in  AW  refill address; low log2(LINE_WORDS) bits ignored.
REQ-008 rd_valid  out  1  refill word valid this cycle.
REQ-009 rd_data  out  DW  refill word, equal to mem_rdata.
REQ-010 rd_word  out  log2(LINE_WORDS)  index of the current refill word within the line.
REQ-011 rd_done  out  1  high with the last rd_valid of a line.
REQ-012 wr_req  in  1  write-through request; held high until wr_ack.
REQ-013 wr_addr  in  AW  write-through word address.
REQ-014 wr_data  in  DW  write-through data.
REQ-015 wr_ack  out  1  write accepted by memory this cycle.
REQ-016 mem_en  out  1  memory access request.
REQ-017 mem_we  out  1  1 = write, 0 = read.
REQ-018 mem_addr  out  AW  memory word address.
REQ-019 mem_wdata  out  DW  memory write data.
REQ-020 mem_rdata  in  DW  memory read data, valid when mem_ready is high.
REQ-021 mem_ready  in  1  completes the current access in the same cycle mem_en is high.
REQ-022 busy  out  1  high whenever state is not IDLE.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, RD_BURST, WR_XFER.
REQ-024 A memory handshake SHALL occur in any cycle with mem_en=1 and mem_ready=1; mem_addr, mem_we and mem_wdata SHALL be stable from mem_en rising until that handshake.
REQ-025 IDLE: mem_en=0; grant on the clock edge; the granted transfer's first mem_en appears the next cycle (1-cycle grant latency).
REQ-026 Arbitration SHALL be round-robin: with only one request, grant it; with both, grant the requester not served last; after reset, rd has priority.
REQ-027 At grant, the block SHALL latch rd_addr with its low index bits zeroed (read grant) or wr_addr/wr_data (write grant); input changes after grant SHALL be ignored.
REQ-028 RD_BURST: mem_en=1, mem_we=0, mem_addr = latched line base | word counter, counter starting at 0.
REQ-029 On each RD_BURST handshake: rd_valid=1, rd_data=mem_rdata, rd_word=counter (combinational, same cycle), then the counter increments.
REQ-030 On the handshake with counter = LINE_WORDS-1: rd_done=1 in the same cycle, the counter wraps to 0, and next state is IDLE.
REQ-031 WR_XFER: mem_en=1, mem_we=1, mem_addr/mem_wdata from latched values; on handshake, wr_ack=1 in the same cycle and next state is IDLE.
REQ-032 A burst or write SHALL never be pre-empted; a request arriving mid-transfer waits for IDLE.
REQ-033 Without mem_ready, the block SHALL wait indefinitely with outputs held (no timeout).
REQ-034 A request dropped before grant SHALL be ignored; a request dropped after grant SHALL not abort the transfer.
REQ-035 Outside handshake cycles: rd_valid, rd_done and wr_ack SHALL be 0, and rd_data is don't-care.
REQ-036 Back-to-back: the IDLE cycle after a completed transfer SHALL re-arbitrate using the updated round-robin pointer.

Reset
REQ-037 When reset is high at a clock edge: state becomes IDLE, counter becomes 0, latched address/data become 0, and the round-robin pointer favours rd.
REQ-038 After reset: mem_en, mem_we, rd_valid, rd_done, wr_ack and busy SHALL be 0, and mem_addr and mem_wdata SHALL be 0.
REQ-039 Reset mid-burst or mid-write SHALL abandon the transfer with no rd_done or wr_ack, and mem_en SHALL be 0 from the following cycle.

Verification
REQ-040 mem_ready=1; rd_req with rd_addr=0x13 at cycle 0 -> mem_addr 0x10,0x11,0x12,0x13 on cycles 1-4; rd_valid on cycles 1-4 with rd_word 0-3; rd_done on cycle 4; busy low on cycle 5.
REQ-041 mem_ready=1; wr_req with wr_addr=0x22, wr_data=0xDEADBEEF -> cycle 1: mem_en=1, mem_we=1, addr 0x22, data 0xDEADBEEF, wr_ack=1; no second write.
REQ-042 rd_req and wr_req together after reset -> read burst first, then write starting one cycle after rd_done; repeat with both requests held -> grants alternate read, write, read.
REQ-043 mem_ready low 3 cycles per word during a refill -> each word takes 4 cycles, mem_addr stable while waiting, rd_valid count = 4, total burst 16 cycles.
REQ-044 reset asserted on the 2nd refill handshake -> no rd_done; mem_en=0 the next cycle; counter 0; a new rd_req with rd_addr=0x40 fetches 0x40-0x43 from word 0.
REQ-045 wr_req arriving during a refill (after its grant) -> wr_ack only after rd_done plus one IDLE cycle; mem_we never high during RD_BURST.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between a cache-line
// refill reader and a write-through writer. One transfer at a time; a burst
// or write runs to completion once granted.
module mem_arbiter #(
    parameter int AW         = 8,
    parameter int DW         = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    // refill read port
    input  logic                          rd_req,
    input  logic [AW-1:0]                 rd_addr,
    output logic                          rd_valid,
    output logic [DW-1:0]                 rd_data,
    output logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic                          rd_done,
    // write-through port
    input  logic                          wr_req,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [DW-1:0]                 wr_data,
    output logic                          wr_ack,
    // memory port
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [AW-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
    input  logic                          mem_ready,
    output logic                          busy
);

    localparam int             IW        = $clog2(LINE_WORDS);
    localparam logic [AW-1:0]  LINE_MASK = AW'(LINE_WORDS - 1);
    localparam logic [IW-1:0]  LAST_WORD = IW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_XFER
    } state_t;

    state_t          state_q;
    logic [IW-1:0]   cnt_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic            prefer_wr_q;   // 1 = read was served last, writer wins a tie

    logic            grant_rd_d;
    logic            grant_wr_d;
    logic [AW-1:0]   line_base_d;
    logic            hs;

    // Arbitration decision for the IDLE cycle and the line-aligned refill base
    always_comb begin
        grant_rd_d  = rd_req && (!wr_req || !prefer_wr_q);
        grant_wr_d  = wr_req && !grant_rd_d;
        line_base_d = rd_addr & ~LINE_MASK;
    end

    // FSM: grant in IDLE, step the refill counter / finish on each handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            prefer_wr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_rd_d) begin
                        state_q     <= RD_BURST;
                        addr_q      <= line_base_d;
                        cnt_q       <= '0;
                        prefer_wr_q <= 1'b1;
                    end else if (grant_wr_d) begin
                        state_q     <= WR_XFER;
                        addr_q      <= wr_addr;
                        wdata_q     <= wr_data;
                        prefer_wr_q <= 1'b0;
                    end
                end
                RD_BURST: begin
                    if (mem_ready) begin
                        // LINE_WORDS is a power of two, so the increment wraps to 0
                        cnt_q <= cnt_q + IW'(1);
                        if (cnt_q == LAST_WORD) begin
                            state_q <= IDLE;
                        end
                    end
                end
                WR_XFER: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Memory-side and requester-side outputs; handshake strobes are suppressed
    // while reset is high so an abandoned transfer never reports completion
    always_comb begin
        mem_en    = (state_q != IDLE);
        mem_we    = (state_q == WR_XFER);
        mem_addr  = addr_q | {{(AW-IW){1'b0}}, cnt_q};
        mem_wdata = wdata_q;
        busy      = (state_q != IDLE);
        hs        = mem_en && mem_ready && !reset;
        rd_valid  = hs && (state_q == RD_BURST);
        rd_data   = mem_rdata;
        rd_word   = cnt_q;
        rd_done   = rd_valid && (cnt_q == LAST_WORD);
        wr_ack    = hs && (state_q == WR_XFER);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (AW=8, DW=32, LINE_WORDS=4).
// Memory read data is a fixed pattern of the address: 0xA50000_<addr>.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [7:0]  rd_addr;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [1:0]  rd_word;
    logic        rd_done;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ack;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = {24'hA50000, mem_addr};

    mem_arbiter #(.AW(8), .DW(32), .LINE_WORDS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_word   (rd_word),
        .rd_done   (rd_done),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy)
    );

    // advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rd_req    = 1'b0;
        rd_addr   = 8'h00;
        wr_req    = 1'b0;
        wr_addr   = 8'h00;
        wr_data   = 32'h0;
        mem_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        rd_req    = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 8'h77;
        wr_data   = 32'hFFFF_FFFF;
        mem_ready = 1'b1;
        tick();
        tick();
        do_reset();
        #1;
        checks++;
        if ({mem_en, mem_we, rd_valid, rd_done, wr_ack, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 000000", {mem_en, mem_we, rd_valid, rd_done, wr_ack, busy});
        end
        checks++;
        if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got addr %h data %h exp 00 00000000", mem_addr, mem_wdata);
        end
    endtask

    task automatic test_read_burst();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 8'h13;
        #1;
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rd_grant_cycle got en %b busy %b exp 0 0", mem_en, busy);
        end
        tick();
        rd_addr = 8'hF0;   // must be ignored after grant
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  ea;
            logic [31:0] ed;
            ea = 8'h10 + 8'(i);
            ed = {24'hA50000, ea};
            #1;
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== ea || rd_valid !== 1'b1 ||
                rd_word !== 2'(i) || rd_data !== ed || rd_done !== (i == 3) || busy !== 1'b1) begin
                errors++;
                $display("FAIL rd_word%0d got en %b we %b addr %h v %b w %0d d %h done %b exp 1 0 %h 1 %0d %h %b",
                         i, mem_en, mem_we, mem_addr, rd_valid, rd_word, rd_data, rd_done, ea, i, ed, i == 3);
            end
            if (i == 3) rd_req = 1'b0;
            tick();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_end got busy %b en %b v %b exp 0 0 0", busy, mem_en, rd_valid);
        end
    endtask

    task automatic test_write();
        // prior read leaves the writer favoured; a lone write is granted anyway
        wr_req  = 1'b1;
        wr_addr = 8'h22;
        wr_data = 32'hDEADBEEF;
        #1;
        checks++;
        if (wr_ack !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL wr_cycle0 got ack %b en %b exp 0 0", wr_ack, mem_en);
        end
        tick();
        wr_addr = 8'h99;
        wr_data = 32'h0;
        #1;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 8'h22 ||
            mem_wdata !== 32'hDEADBEEF || wr_ack !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wr_cycle1 got en %b we %b addr %h data %h ack %b exp 1 1 22 deadbeef 1",
                     mem_en, mem_we, mem_addr, mem_wdata, wr_ack);
        end
        wr_req = 1'b0;
        tick();
        #1;
        checks++;
        if (mem_en !== 1'b0 || wr_ack !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wr_after1 got en %b ack %b busy %b exp 0 0 0", mem_en, wr_ack, busy);
        end
        tick();
        #1;
        checks++;
        if (mem_en !== 1'b0 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_after2 got en %b ack %b exp 0 0", mem_en, wr_ack);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 8'h31;
        wr_req  = 1'b1;
        wr_addr = 8'h55;
        wr_data = 32'h12345678;
        tick();
        // cycles 1-4: read burst of line 0x30
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h30 + 8'(i) || wr_ack !== 1'b0) begin
                errors++;
                $display("FAIL arb_rd%0d got en %b we %b addr %h ack %b exp 1 0 %h 0",
                         i, mem_en, mem_we, mem_addr, wr_ack, 8'h30 + 8'(i));
            end
            tick();
        end
        // cycle 5: IDLE re-arbitration
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_idle1 got busy %b exp 0", busy);
        end
        tick();
        // cycle 6: write wins because read was served last
        #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 8'h55 || mem_wdata !== 32'h12345678 || wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL arb_wr got we %b addr %h data %h ack %b exp 1 55 12345678 1",
                     mem_we, mem_addr, mem_wdata, wr_ack);
        end
        tick();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL arb_idle2 got busy %b exp 0", busy);
        end
        tick();
        // cycle 8: read again
        #1;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h30 || rd_word !== 2'd0) begin
            errors++;
            $display("FAIL arb_rd2 got en %b we %b addr %h w %0d exp 1 0 30 0", mem_en, mem_we, mem_addr, rd_word);
        end
        rd_req = 1'b0;
        wr_req = 1'b0;
    endtask

    task automatic test_wait_states();
        int nvalid;
        int done_cyc;
        do_reset();
        nvalid   = 0;
        done_cyc = -1;
        rd_req   = 1'b1;
        rd_addr  = 8'h86;
        tick();
        for (int c = 1; c <= 16; c++) begin
            logic [7:0] ea;
            mem_ready = ((c - 1) % 4 == 3);
            ea = 8'h84 + 8'((c - 1) / 4);
            #1;
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== ea || rd_valid !== mem_ready) begin
                errors++;
                $display("FAIL ws_cyc%0d got en %b addr %h v %b exp 1 %h %b", c, mem_en, mem_addr, rd_valid, ea, mem_ready);
            end
            if (rd_valid === 1'b1) nvalid++;
            if (rd_done === 1'b1) begin
                done_cyc = c;
                rd_req   = 1'b0;
            end
            tick();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (nvalid != 4 || done_cyc != 16 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ws_summary got valids %0d done_cyc %0d busy %b exp 4 16 0", nvalid, done_cyc, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rd_req  = 1'b1;
        rd_addr = 8'h20;
        tick();
        tick();
        // second handshake cycle: reset asserted here
        reset = 1'b1;
        #1;
        checks++;
        if (rd_done !== 1'b0 || rd_word !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid got done %b w %0d exp 0 1", rd_done, rd_word);
        end
        tick();
        reset   = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 8'h40;
        #1;
        checks++;
        if (mem_en !== 1'b0 || busy !== 1'b0 || rd_word !== 2'd0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL rst_after got en %b busy %b w %0d addr %h exp 0 0 0 00", mem_en, busy, rd_word, mem_addr);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (mem_addr !== 8'h40 + 8'(i) || rd_word !== 2'(i) || rd_valid !== 1'b1 || rd_done !== (i == 3)) begin
                errors++;
                $display("FAIL rst_refill%0d got addr %h w %0d v %b done %b exp %h %0d 1 %b",
                         i, mem_addr, rd_word, rd_valid, rd_done, 8'h40 + 8'(i), i, i == 3);
            end
            if (i == 3) rd_req = 1'b0;
            tick();
        end
    endtask

    task automatic test_wr_during_burst();
        int done_cyc;
        int ack_cyc;
        int we_bad;
        int idle_bad;
        do_reset();
        done_cyc = -1;
        ack_cyc  = -1;
        we_bad   = 0;
        idle_bad = 0;
        rd_req   = 1'b1;
        rd_addr  = 8'h50;
        tick();
        wr_req  = 1'b1;
        wr_addr = 8'h66;
        wr_data = 32'hCAFE0001;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (rd_valid === 1'b1 && mem_we !== 1'b0) we_bad++;
            if (c == 5 && busy !== 1'b0) idle_bad++;
            if (rd_done === 1'b1) begin
                done_cyc = c;
                rd_req   = 1'b0;
            end
            if (wr_ack === 1'b1) begin
                ack_cyc = c;
                wr_req  = 1'b0;
            end
            tick();
            if (ack_cyc > 0) break;
        end
        checks++;
        if (done_cyc != 4 || ack_cyc != 6) begin
            errors++;
            $display("FAIL wdb_timing got done %0d ack %0d exp 4 6", done_cyc, ack_cyc);
        end
        checks++;
        if (we_bad != 0 || idle_bad != 0) begin
            errors++;
            $display("FAIL wdb_we got we_in_burst %0d idle_miss %0d exp 0 0", we_bad, idle_bad);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read_burst();
        test_write();
        test_arbitration();
        test_wait_states();
        test_reset_mid_burst();
        test_wr_during_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
